// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the architectural HI/LO.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; division always iterates.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state;
    logic [4:0]         r_cnt;
    logic               r_is_div;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               r_dbz;
    logic               r_done;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_acc;

    logic               w_accept;
    logic               w_iter_op;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH-1:0]   w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_a;
    logic [2*WIDTH-1:0] w_fast_b;
    logic [2*WIDTH-1:0] w_fast_prod;
`endif

    always_comb begin
        w_accept = (r_state == S_IDLE) & start & ~flush;
`ifdef MULDIV_FAST_MUL_EN
        w_iter_op = ~op[2] & op[1];
`else
        w_iter_op = ~op[2];
`endif
        w_a_neg = ~op[0] & src_a[WIDTH-1];
        w_b_neg = ~op[0] & src_b[WIDTH-1];
        w_a_mag = w_a_neg ? (~src_a + 1'b1) : src_a;
        w_b_mag = w_b_neg ? (~src_b + 1'b1) : src_b;

        // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right with carry.
        w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
        // Divide: acc = {remainder, dividend/quotient}; shift left, subtract if it fits.
        w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
        w_ge     = (w_rem_sh >= {1'b0, r_m});
        w_diff   = w_rem_sh[WIDTH-1:0] - r_m;

        if (r_is_div)
            w_step = {(w_ge ? w_diff : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
        else
            w_step = {w_mul_sum, r_acc[WIDTH-1:1]};

        w_quo  = w_step[WIDTH-1:0];
        w_rem  = w_step[2*WIDTH-1:WIDTH];
        w_prod = r_neg_lo ? (~w_step + 1'b1) : w_step;

        if (r_is_div) begin
            if (r_dbz) begin
                w_res_hi = r_a_raw;
                w_res_lo = '1;
            end else begin
                w_res_hi = r_neg_hi ? (~w_rem + 1'b1) : w_rem;
                w_res_lo = r_neg_lo ? (~w_quo + 1'b1) : w_quo;
            end
        end else begin
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end

`ifdef MULDIV_FAST_MUL_EN
        // Sign-extended operands make the truncated 64-bit product correct for MULT too.
        w_fast_a    = op[0] ? {{WIDTH{1'b0}}, src_a} : {{WIDTH{src_a[WIDTH-1]}}, src_a};
        w_fast_b    = op[0] ? {{WIDTH{1'b0}}, src_b} : {{WIDTH{src_b[WIDTH-1]}}, src_b};
        w_fast_prod = w_fast_a * w_fast_b;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_dbz    <= 1'b0;
            r_done   <= 1'b0;
            r_m      <= '0;
            r_a_raw  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (op == 3'd4) begin
                            r_hi <= src_a;
                        end else if (op == 3'd5) begin
                            r_lo <= src_a;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (~op[2] & ~op[1]) begin
                            r_hi   <= w_fast_prod[2*WIDTH-1:WIDTH];
                            r_lo   <= w_fast_prod[WIDTH-1:0];
                            r_done <= 1'b1;
`endif
                        end else if (~op[2]) begin
                            r_is_div <= op[1];
                            r_neg_lo <= w_a_neg ^ w_b_neg;
                            r_neg_hi <= op[1] & w_a_neg;
                            r_dbz    <= op[1] & (src_b == '0);
                            r_a_raw  <= src_a;
                            r_m      <= op[1] ? w_b_mag : w_a_mag;
                            r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
                            r_cnt    <= '0;
                            r_state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == '1) begin
                            r_hi    <= w_res_hi;
                            r_lo    <= w_res_lo;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_RUN) | (w_accept & w_iter_op);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed scoreboard bench for muldiv_ctrl: expected HI:LO queued at issue, checked on done.
// Honours MULDIV_FAST_MUL_EN (MULT/MULTU complete in one cycle when defined).
module tb_muldiv_ctrl;
    logic        clk;
    logic        resetn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned total;
    int unsigned bad;
    logic [63:0] sb[$];

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a long op at the current (post-negedge) time; checks busy every cycle and
    // pops the scoreboard when done is due. Returns in the done cycle with start low.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        logic        fast;
        int unsigned lat;
        logic [63:0] e;
        fast = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
        fast = (o < 3'd2);
`endif
        lat = fast ? 1 : 33;
        sb.push_back({eh, el});
        start = 1'b1; op = o; src_a = a; src_b = b; flush = 1'b0;
        #1;
        chk1({tag, "_busy_req"}, busy, ~fast);
        for (int k = 1; k <= int'(lat); k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                src_a = $urandom;
                src_b = $urandom;
            end
            #1;
            if (k < int'(lat)) begin
                if (busy !== 1'b1 || done !== 1'b0)
                    chk1($sformatf("%s_busy_run_k%0d", tag, k), busy & ~done, 1'b1);
            end else begin
                chk1({tag, "_busy_end"}, busy, 1'b0);
                chk1({tag, "_done"}, done, 1'b1);
                if (done === 1'b1 && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk32({tag, "_hi"}, hi, e[63:32]);
                    chk32({tag, "_lo"}, lo, e[31:0]);
                end
            end
        end
    endtask

    initial begin
        logic        seen_done;
        logic [31:0] lo_hold;
        total = 0; bad = 0;
        resetn = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk32("rst_hi", hi, 32'h0);
        chk32("rst_lo", lo, 32'h0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        @(negedge clk); #1;
        chk1("done_pulse_one_cycle", done, 1'b0);

        @(negedge clk);
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_by_zero", 3'd2, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        run_op("divu_0_0", 3'd3, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF);
        run_op("fast_mult", 3'd0, 32'd6, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFE8);

        // MTHI / MTLO, flushed MTLO, reserved op
        @(negedge clk);
        start = 1'b1; op = 3'd4; src_a = 32'hDEAD_BEEF;
        #1; chk1("mthi_busy", busy, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd5; src_a = 32'h0BAD_F00D;
        #1;
        chk32("mthi_hi", hi, 32'hDEAD_BEEF);
        chk1("mthi_no_done", done, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd5; src_a = 32'h1111_2222; flush = 1'b1;
        #1;
        chk32("mtlo_lo", lo, 32'h0BAD_F00D);
        @(negedge clk);
        flush = 1'b0; op = 3'd6; src_a = 32'h3333_4444;
        #1;
        chk32("flushed_mtlo_lo", lo, 32'h0BAD_F00D);
        chk1("reserved_busy", busy, 1'b0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk32("reserved_hi", hi, 32'hDEAD_BEEF);
        chk32("reserved_lo", lo, 32'h0BAD_F00D);
        chk1("reserved_no_done", done, 1'b0);

        // Long op flushed in RUN at T+10 while start stays high
        @(negedge clk);
        start = 1'b1; op = 3'd3; src_a = 32'd1000; src_b = 32'd3;
        #1; chk1("flush_busy_req", busy, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 10) flush = 1'b1;
            #1;
            if (busy !== 1'b1) chk1($sformatf("flush_busy_run_k%0d", k), busy, 1'b1);
        end
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        #1;
        chk1("flush_busy_low", busy, 1'b0);
        seen_done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (done === 1'b1) seen_done = 1'b1;
            @(negedge clk); #1;
        end
        chk1("flush_no_done", seen_done, 1'b0);
        chk32("flush_hi_kept", hi, 32'hDEAD_BEEF);
        chk32("flush_lo_kept", lo, 32'h0BAD_F00D);

        // Asynchronous reset in the middle of a DIV
        @(negedge clk);
        start = 1'b1; op = 3'd2; src_a = 32'd100; src_b = 32'd7;
        lo_hold = lo;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        chk1("pre_rst_busy", busy, 1'b1);
        resetn = 1'b0;
        #1;
        chk1("mid_rst_busy", busy, 1'b0);
        chk32("mid_rst_hi", hi, 32'h0);
        chk32("mid_rst_lo", lo, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        chk1("post_rst_idle", seen_done, 1'b0);
        run_op("multu_after_rst", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE);

        chk1("scoreboard_empty", sb.size() == 0, 1'b1);
        if (lo_hold == 32'h0) chk1("mid_rst_precond", 1'b0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
